// File: rtl/burst_memory_responder.sv
// Burst memory responder: 2^ADDR_BITS lines of 256 bits moved as four 64-bit beats after LATENCY wait cycles.
// Optional protocol checking is enabled by defining BURST_MEM_PROTOCOL_CHECK_EN.
module burst_memory_responder #(
    parameter int ADDR_BITS = 4,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, LAT, BEAT, DONE} state_t;

    localparam int WORDS = 1 << (ADDR_BITS + 2);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    state_t                 state_reg, state_next;
    logic [3:0]             lat_cnt_reg, lat_cnt_next;
    logic [1:0]             beat_reg, beat_next;
    logic [ADDR_BITS-1:0]   idx_reg, idx_next;
    logic                   op_rd_reg, op_rd_next;

    // Storage is one 64-bit word per beat, addressed {line index, beat}
    logic [63:0]            mem [WORDS];
    logic [63:0]            rdata_reg;
    logic [ADDR_BITS+1:0]   rd_addr;
    logic [ADDR_BITS+1:0]   wr_addr;
    logic                   wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= '0;
            beat_reg    <= '0;
            idx_reg     <= '0;
            op_rd_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            beat_reg    <= beat_next;
            idx_reg     <= idx_next;
            op_rd_reg   <= op_rd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        beat_next    = beat_reg;
        idx_next     = idx_reg;
        op_rd_next   = op_rd_reg;
        case (state_reg)
            IDLE: begin
                if (read_i || write_i) begin
                    idx_next   = address_i[ADDR_BITS+4:5];
                    op_rd_next = read_i;
                    if (LATENCY == 0) begin
                        state_next = BEAT;
                    end else begin
                        state_next   = LAT;
                        lat_cnt_next = LAT_LOAD;
                    end
                end
            end
            LAT: begin
                if (lat_cnt_reg == 4'd0) begin
                    state_next = BEAT;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            BEAT: begin
                beat_next = beat_reg + 2'd1;
                if (beat_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The read port looks one cycle ahead so each beat's word is already registered when the beat starts
    assign rd_addr = {idx_next, beat_next};
    assign wr_addr = {idx_reg, beat_reg};
    assign wr_en   = (state_reg == BEAT) && !op_rd_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= burst_i;
        end
        rdata_reg <= mem[rd_addr];
    end

    assign resp_o  = (state_reg == BEAT);
    assign burst_o = (state_reg == BEAT && op_rd_reg) ? rdata_reg : 64'd0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_i[4:0], address_i[31:ADDR_BITS+5]};

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
    logic        err_reg;
    logic [26:0] line_addr_reg;
    logic        req_held;

    assign req_held = op_rd_reg ? read_i : write_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg       <= 1'b0;
            line_addr_reg <= '0;
        end else begin
            if (state_reg == IDLE && (read_i || write_i)) begin
                line_addr_reg <= address_i[31:5];
                if (read_i && write_i) begin
                    err_reg <= 1'b1;
                end
            end
            if ((state_reg == LAT || state_reg == BEAT) &&
                (!req_held || address_i[31:5] != line_addr_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_burst_memory_responder.sv
// Bench for burst_memory_responder: directed table, hand-written corner sequences and random
// transactions against a transaction-level memory model, on a LATENCY=3 and a LATENCY=0 instance.
module tb_burst_memory_responder;

    localparam int AB = 4;
    localparam int L3 = 3;
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic        drv_rd, drv_wr;
    logic [63:0] burst_in;
    int          sel;

    logic        rd3, wr3, rd0, wr0;
    logic [63:0] burst3, burst0, burst_s;
    logic        resp3, resp0, err3, err0, resp_s;

    int vectors = 0;
    int miscompares = 0;

    // Model memory per instance: [instance][line][word], plus written flags
    logic [63:0] mm [2][16][4];
    bit          mv [2][16][4];

    always #5 clk = ~clk;

    assign rd3     = drv_rd && (sel == 0);
    assign wr3     = drv_wr && (sel == 0);
    assign rd0     = drv_rd && (sel == 1);
    assign wr0     = drv_wr && (sel == 1);
    assign burst_s = (sel == 1) ? burst0 : burst3;
    assign resp_s  = (sel == 1) ? resp0 : resp3;

    burst_memory_responder #(.ADDR_BITS(AB), .LATENCY(L3)) dut3 (
        .clk(clk), .reset_n(reset_n), .address_i(address), .read_i(rd3), .write_i(wr3),
        .burst_i(burst_in), .burst_o(burst3), .resp_o(resp3), .err_o(err3)
    );

    burst_memory_responder #(.ADDR_BITS(AB), .LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address_i(address), .read_i(rd0), .write_i(wr0),
        .burst_i(burst_in), .burst_o(burst0), .resp_o(resp0), .err_o(err0)
    );

    typedef struct {
        string           name;
        bit              wr;
        logic [31:0]     addr;
        logic [3:0][63:0] data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][63:0] mk(input logic [63:0] w0, input logic [63:0] w1,
                                             input logic [63:0] w2, input logic [63:0] w3);
        logic [3:0][63:0] r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        return r;
    endfunction

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    // One transaction, starting just after a clock edge with the selected DUT idle.
    // mode 0: drop request and scramble address after acceptance; 1: hold stable; 2: hold, flip addr bit 5 in LAT.
    task automatic do_txn(input bit wr, input bit both, input logic [31:0] addr, input int mode,
                          input bit use_exp, input logic [3:0][63:0] data);
        int lat = (sel == 1) ? 0 : L3;
        int idx = int'(addr[AB+4:5]);
        bit is_rd = !wr || both;
        drv_rd  = is_rd;
        drv_wr  = wr || both;
        address = addr;
        @(posedge clk); #1;
        if (mode == 0) begin
            drv_rd  = 1'b0;
            drv_wr  = 1'b0;
            address = $urandom;
        end
        for (int c = 0; c < lat; c++) begin
            if (mode == 2 && c == 0) address = addr ^ 32'h20;
            check("lat_resp", resp_s, 0);
            check("lat_burst", burst_s, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            burst_in = is_rd ? {$urandom, $urandom} : data[k];
            check("beat_resp", resp_s, 1);
            if (is_rd) begin
                if (use_exp) check("rd_data", burst_s, data[k]);
                else if (mv[sel][idx][k]) check("rd_model", burst_s, mm[sel][idx][k]);
            end else begin
                check("wr_burst_zero", burst_s, 0);
            end
            @(posedge clk); #1;
            if (!is_rd) begin
                mm[sel][idx][k] = data[k];
                mv[sel][idx][k] = 1'b1;
            end
        end
        check("done_resp", resp_s, 0);
        check("done_burst", burst_s, 0);
        if (mode == 0) begin
            // A request during DONE must be ignored
            drv_rd  = 1'($urandom_range(0, 1));
            drv_wr  = 1'($urandom_range(0, 1));
            address = $urandom;
        end
        @(posedge clk); #1;
        drv_rd = 1'b0;
        drv_wr = 1'b0;
    endtask

    // Read of line 2 (address 0x40) held high for n back-to-back transactions
    task automatic b2b(input int n);
        int lat = (sel == 1) ? 0 : L3;
        int per = lat + 6;
        drv_rd  = 1'b1;
        address = 32'h40;
        @(posedge clk); #1;
        for (int s = 0; s < n * per; s++) begin
            int o = s % per;
            if (o >= lat && o < lat + 4) begin
                check("b2b_resp", resp_s, 1);
                check("b2b_burst", burst_s, mm[sel][2][o - lat]);
            end else begin
                check("b2b_gap_resp", resp_s, 0);
                check("b2b_gap_burst", burst_s, 0);
            end
            if (s == n * per - 1) drv_rd = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        check("rst_resp", resp_s, 0);
        check("rst_burst", burst_s, 0);
        check("rst_err", err3, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t tbl [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][63:0] nw;
        tbl[0] = '{"wr_line40", 1'b1, 32'h0000_0040, mk(rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44))};
        tbl[1] = '{"rd_line40", 1'b0, 32'h0000_0040, mk(rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44))};
        tbl[2] = '{"rd_line47", 1'b0, 32'h0000_0047, mk(rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44))};
        tbl[3] = '{"wr_line1e0", 1'b1, 32'h0000_01E0, mk(rep(8'hAA), rep(8'hBB), rep(8'hCC), rep(8'hDD))};
        tbl[4] = '{"rd_line1ff", 1'b0, 32'h0000_01FF, mk(rep(8'hAA), rep(8'hBB), rep(8'hCC), rep(8'hDD))};
        tbl[5] = '{"wr_line40b", 1'b1, 32'h0000_0040, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88))};
        tbl[6] = '{"rd_hi_alias", 1'b0, 32'hFFFF_FE43, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88))};

        sel = 0; drv_rd = 0; drv_wr = 0; address = 0; burst_in = 0;
        reset_n = 1'b0;
        #12;
        check("reset_resp3", resp3, 0);
        check("reset_burst3", burst3, 0);
        check("reset_err3", err3, 0);
        check("reset_resp0", resp0, 0);
        check("reset_burst0", burst0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            $display("txn %0d %s addr=%h", i, tbl[i].name, tbl[i].addr);
            do_txn(tbl[i].wr, 1'b0, tbl[i].addr, 0, !tbl[i].wr, tbl[i].data);
        end

        $display("txn back-to-back x3 latency 3");
        b2b(3);

        // Reset arriving just after the edge that commits word 1 of a write
        $display("txn reset mid-write line 0x1e0");
        nw = mk(rep(8'hE0), rep(8'hE1), rep(8'hE2), rep(8'hE3));
        drv_wr = 1'b1; address = 32'h1E0;
        @(posedge clk); #1;
        drv_wr = 1'b0;
        repeat (L3) begin @(posedge clk); #1; end
        burst_in = nw[0];
        check("mw_beat0", resp3, 1);
        @(posedge clk); #1;
        burst_in = nw[1];
        check("mw_beat1", resp3, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mw_rst_resp", resp3, 0);
        check("mw_rst_burst", burst3, 0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("mw_after_resp", resp3, 0);
        mm[0][15][0] = nw[0];
        mm[0][15][1] = nw[1];
        do_txn(1'b0, 1'b0, 32'h1E0, 0, 1'b1, mk(nw[0], nw[1], rep(8'hCC), rep(8'hDD)));

        $display("txn latency 0 write/read/back-to-back");
        sel = 1;
        do_txn(1'b1, 1'b0, 32'h40, 0, 1'b0, mk(rep(8'h91), rep(8'h92), rep(8'h93), rep(8'h94)));
        do_txn(1'b0, 1'b0, 32'h40, 0, 1'b1, mk(rep(8'h91), rep(8'h92), rep(8'h93), rep(8'h94)));
        b2b(2);

        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 30; i++) begin
                bit          wr = 1'($urandom_range(0, 1));
                logic [31:0] a  = $urandom;
                $display("txn random inst=%0d wr=%0d addr=%h", s, wr, a);
                do_txn(wr, 1'b0, a, int'($urandom_range(0, 1)), 1'b0,
                       mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}));
            end
        end

        $display("txn protocol error checks");
        sel = 0;
        do_txn(1'b1, 1'b0, 32'h40, 1, 1'b0, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)));
        pulse_reset();
        do_txn(1'b0, 1'b1, 32'h40, 1, 1'b1, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)));
        check("err_both", err3, EXP_ERR);
        do_txn(1'b0, 1'b0, 32'h40, 1, 1'b1, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)));
        check("err_sticky", err3, EXP_ERR);
        pulse_reset();
        do_txn(1'b0, 1'b0, 32'h40, 1, 1'b1, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)));
        check("err_clean", err3, 0);
        do_txn(1'b0, 1'b0, 32'h40, 2, 1'b1, mk(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)));
        check("err_addr_flip", err3, EXP_ERR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
